// File: rtl/ext_mem_responder.sv
// External memory bus responder backed by a word-addressed RAM window, with programmable wait
// states and error flagging. Define EXT_MEM_STATS_EN to add saturating transfer counters.
module ext_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h00010000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic        ext_mem_read,
    input  logic        ext_mem_write,
    input  logic        ext_mem_enable,
    output logic        ext_mem_ready,
    output logic [31:0] ext_rdata,
    output logic        ext_rdata_oe,
    output logic        ext_mem_error,
    output logic        busy
`ifdef EXT_MEM_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] err_count
`endif
);

    localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WinLo   = {1'b0, BASE_ADDR};
    localparam logic [32:0] WinHi   = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAck, StRelease} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        oe_q, oe_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic            req;
    logic            go_ack;
    logic [31:0]     cur_addr;
    logic [31:0]     cur_wdata;
    logic            cur_rd;
    logic            cur_wr;
    logic            cur_err;
    logic [IdxW-1:0] cur_idx;
    logic            ram_we;

    assign req = ext_mem_enable & (ext_mem_read | ext_mem_write);

    // A zero-wait transfer commits at the accepting edge, so IDLE must use the live inputs.
    always_comb begin
        cur_addr  = (state_q == StIdle) ? ext_addr      : addr_q;
        cur_wdata = (state_q == StIdle) ? ext_wdata     : wdata_q;
        cur_rd    = (state_q == StIdle) ? ext_mem_read  : rd_q;
        cur_wr    = (state_q == StIdle) ? ext_mem_write : wr_q;
        cur_err   = (cur_rd & cur_wr) | (cur_addr[1:0] != 2'b00) |
                    ({1'b0, cur_addr} < WinLo) | ({1'b0, cur_addr} >= WinHi);
        cur_idx   = cur_addr[IdxW+1:2] - BASE_ADDR[IdxW+1:2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        go_ack  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = ext_addr;
                    wdata_d = ext_wdata;
                    rd_d    = ext_mem_read;
                    wr_d    = ext_mem_write;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StAck;
                        go_ack  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAck;
                    go_ack  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: state_d = StRelease;
            StRelease: begin
                // Wait for the strobe to drop so a held request cannot commit twice.
                if (!ext_mem_enable || (!ext_mem_read && !ext_mem_write)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_d = go_ack;
        oe_d    = go_ack & cur_rd;
        err_d   = go_ack & cur_err;
        rdata_d = rdata_q;
        if (go_ack && cur_rd) begin
            rdata_d = cur_err ? ERR_DATA : mem[cur_idx];
        end
        ram_we = go_ack & cur_wr & ~cur_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            oe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            oe_q    <= oe_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    assign ext_mem_ready = ready_q;
    assign ext_rdata     = rdata_q;
    assign ext_rdata_oe  = oe_q;
    assign ext_mem_error = err_q;
    assign busy          = (state_q != StIdle);

`ifdef EXT_MEM_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        if (go_ack) begin
            if (cur_err) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end else if (cur_rd) begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
            end else begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q  <= 16'd0;
            wr_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ext_mem_responder.sv
// Randomized scoreboard bench for ext_mem_responder: a main instance with two wait states and a
// zero-wait instance, checked against an address-keyed memory model.
module tb_ext_mem_responder;

    localparam logic [31:0] BASE  = 32'h00010000;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned WAITC = 2;
    localparam logic [31:0] ERRD  = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ext_addr = '0, ext_wdata = '0;
    logic        ext_mem_read = 1'b0, ext_mem_write = 1'b0, ext_mem_enable = 1'b0;
    logic        ext_mem_ready, ext_rdata_oe, ext_mem_error, busy;
    logic [31:0] ext_rdata;

    logic [31:0] z_addr = '0, z_wdata = '0;
    logic        z_rd = 1'b0, z_wr = 1'b0, z_en = 1'b0;
    logic        z_ready, z_oe, z_err, z_busy;
    logic [31:0] z_rdata;

`ifdef EXT_MEM_STATS_EN
    logic [15:0] rd_count, wr_count, err_count;
    logic [15:0] z_rdc, z_wrc, z_errc;
`endif

    always #5 clk = ~clk;

    ext_mem_responder #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .ERR_DATA(ERRD)
    ) dut (
        .clk(clk), .rst(rst), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_mem_read(ext_mem_read), .ext_mem_write(ext_mem_write),
        .ext_mem_enable(ext_mem_enable), .ext_mem_ready(ext_mem_ready), .ext_rdata(ext_rdata),
        .ext_rdata_oe(ext_rdata_oe), .ext_mem_error(ext_mem_error), .busy(busy)
`ifdef EXT_MEM_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
    );

    ext_mem_responder #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ERR_DATA(ERRD)
    ) dut_z (
        .clk(clk), .rst(rst), .ext_addr(z_addr), .ext_wdata(z_wdata),
        .ext_mem_read(z_rd), .ext_mem_write(z_wr), .ext_mem_enable(z_en),
        .ext_mem_ready(z_ready), .ext_rdata(z_rdata), .ext_rdata_oe(z_oe),
        .ext_mem_error(z_err), .busy(z_busy)
`ifdef EXT_MEM_STATS_EN
        , .rd_count(z_rdc), .wr_count(z_wrc), .err_count(z_errc)
`endif
    );

    typedef struct {
        logic        rd;
        logic        err;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [logic [31:0]];
    int          n_checks = 0;
    int          n_err    = 0;
    int          m_rd = 0, m_wr = 0, m_errc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding transfer.
    always @(negedge clk) begin
        if (!rst && ext_mem_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("error_flag", 32'(ext_mem_error), 32'(e.err));
                check("rdata_oe", 32'(ext_rdata_oe), 32'(e.rd));
                if (e.rd && e.chk) check("rdata", ext_rdata, e.data);
            end
        end
        if (!rst && ext_rdata_oe && !ext_mem_ready) check("oe_without_ready", 32'd1, 32'd0);
    end

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic rd,
                        input logic wr, input int hold, input bit scramble);
        exp_t e;
        int   n;
        logic err;
        err = (rd && wr) || (a % 4 != 0) || (a < BASE) || (a >= BASE + 4 * DEPTH);
        e.rd = rd; e.err = err; e.chk = 1'b0; e.data = '0;
        if (rd) begin
            if (err) begin
                e.chk = 1'b1; e.data = ERRD;
            end else if (mem_m.exists(a)) begin
                e.chk = 1'b1; e.data = mem_m[a];
            end
        end
        if (err) m_errc++;
        else if (rd) m_rd++;
        else begin
            m_wr++;
            mem_m[a] = d;
        end
        sb.push_back(e);
        ext_addr = a; ext_wdata = d; ext_mem_read = rd; ext_mem_write = wr; ext_mem_enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (scramble && !ext_mem_ready) begin
                ext_addr  = $urandom;
                ext_wdata = $urandom;
            end
        end while (!ext_mem_ready && n < 40);
        check("latency", 32'(n), 32'(WAITC + 1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("held_no_ready", 32'(ext_mem_ready), 32'd0);
            check("held_busy", 32'(busy), 32'd1);
        end
        ext_mem_enable = 1'b0; ext_mem_read = 1'b0; ext_mem_write = 1'b0;
        if (hold > 0) begin
            @(negedge clk);
            check("busy_after_release", 32'(busy), 32'd0);
        end else begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (busy && n < 10);
            check("busy_drops", 32'(busy), 32'd0);
        end
    endtask

    task automatic zxfer(input logic [31:0] a, input logic [31:0] d, input logic rd,
                         input logic wr, output int n, output logic [31:0] rdata,
                         output logic err, output logic oe);
        z_addr = a; z_wdata = d; z_rd = rd; z_wr = wr; z_en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!z_ready && n < 20);
        rdata = z_rdata; err = z_err; oe = z_oe;
        z_en = 1'b0; z_rd = 1'b0; z_wr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int          n;
        logic [31:0] rdv;
        logic        errv, oev;
        logic [31:0] a;
        int          sel, op;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ext_mem_ready), 32'd0);
        check("rst_rdata", ext_rdata, 32'd0);
        check("rst_oe", 32'(ext_rdata_oe), 32'd0);
        check("rst_error", 32'(ext_mem_error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        xfer(32'h00010010, 32'hCAFEBABE, 1'b0, 1'b1, 0, 1'b0);
        xfer(32'h00010010, 32'h0, 1'b1, 1'b0, 0, 1'b0);

        xfer(32'h00010000, 32'h12345678, 1'b0, 1'b1, 0, 1'b0);
        xfer(32'h00014000, 32'h0, 1'b1, 1'b0, 0, 1'b0);
        xfer(32'h00010002, 32'h11111111, 1'b0, 1'b1, 0, 1'b0);
        xfer(32'h00010000, 32'h0, 1'b1, 1'b0, 0, 1'b0);

        xfer(32'h00010020, 32'h0F0F0F0F, 1'b0, 1'b1, 0, 1'b0);
        xfer(32'h00010020, 32'hFFFFFFFF, 1'b1, 1'b1, 0, 1'b0);
        xfer(32'h00010020, 32'h0, 1'b1, 1'b0, 0, 1'b0);

        xfer(32'h00010030, 32'hABCD0001, 1'b0, 1'b1, 10, 1'b0);
        xfer(32'h00010030, 32'h0, 1'b1, 1'b0, 0, 1'b0);

        // Abort a write during its wait states.
        xfer(32'h00010040, 32'h0BADF00D, 1'b0, 1'b1, 0, 1'b0);
        ext_addr = 32'h00010040; ext_wdata = 32'h55555555;
        ext_mem_write = 1'b1; ext_mem_enable = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", 32'(ext_mem_ready), 32'd0);
        check("midrst_rdata", ext_rdata, 32'd0);
        check("midrst_oe", 32'(ext_rdata_oe), 32'd0);
        check("midrst_error", 32'(ext_mem_error), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        ext_mem_enable = 1'b0; ext_mem_write = 1'b0;
        rst = 1'b0;
        m_rd = 0; m_wr = 0; m_errc = 0;
        @(negedge clk);
        xfer(32'h00010040, 32'h0, 1'b1, 1'b0, 0, 1'b0);
        xfer(32'h00010044, 32'h00000044, 1'b0, 1'b1, 0, 1'b1);
        xfer(32'h00010048, 32'h00000048, 1'b0, 1'b1, 0, 1'b1);
        xfer(32'h00010044, 32'h0, 1'b1, 1'b0, 0, 1'b1);
        xfer(32'h00010048, 32'h0, 1'b1, 1'b0, 0, 1'b0);
        xfer(32'h00014000, 32'h0, 1'b1, 1'b0, 0, 1'b0);
`ifdef EXT_MEM_STATS_EN
        check("rd_count", 32'(rd_count), 32'd3);
        check("wr_count", 32'(wr_count), 32'd2);
        check("err_count", 32'(err_count), 32'd1);
`endif

        zxfer(BASE, 32'hA5A50001, 1'b0, 1'b1, n, rdv, errv, oev);
        check("z_write_latency", 32'(n), 32'd1);
        check("z_write_error", 32'(errv), 32'd0);
        zxfer(BASE, 32'h0, 1'b1, 1'b0, n, rdv, errv, oev);
        check("z_read_latency", 32'(n), 32'd1);
        check("z_read_data", rdv, 32'hA5A50001);
        check("z_read_oe", 32'(oev), 32'd1);

        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            a   = BASE + 4 * $urandom_range(0, 15);
            if (sel == 0) a = a | 32'($urandom_range(1, 3));
            if (sel == 1) a = BASE - 4;
            if (sel == 2) a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
            if (sel == 3) a = 32'hFFFFFFFC;
            op = int'($urandom_range(0, 6));
            xfer(a, $urandom, (op <= 2 || op == 6), (op >= 3), int'($urandom_range(0, 2)),
                 bit'($urandom_range(0, 1)));
        end
`ifdef EXT_MEM_STATS_EN
        check("rd_count_final", 32'(rd_count), 32'(m_rd));
        check("wr_count_final", 32'(wr_count), 32'(m_wr));
        check("err_count_final", 32'(err_count), 32'(m_errc));
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
